switch_led_ctrl: RTL and testbench

- Controller between the kit's 4 raw push switches and its 4 LEDs.
- Synchronises and debounces each switch, and detects clean press edges.
- A short press toggles the corresponding LED latch; holding any switch for LONG_CYCLES clears all latches.
- Drives the active-low LED pins directly. Sits at top level in place of the direct switch-to-LED wiring.

---
 rtl/switch_led_ctrl.sv | 144 ++++++++++++++
 tb/tb_switch_led_ctrl.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/switch_led_ctrl.sv
// Push-switch front end for the 4 kit LEDs: synchronise, debounce, toggle a
// per-LED latch on each press, and clear all latches on a long hold.
module switch_led_ctrl #(
    parameter int DEBOUNCE_CYCLES = 240000,
    parameter int LONG_CYCLES     = 24000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] sw,
    output logic [3:0] led_n,
    output logic [3:0] press_pulse,
    output logic       long_pulse,
    output logic [3:0] held
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES);
    localparam int LW = $clog2(LONG_CYCLES);
    localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [LW-1:0] LONG_LAST = LW'(LONG_CYCLES - 1);

    typedef enum logic [1:0] {
        HOLD_IDLE     = 2'd0,
        HOLD_COUNTING = 2'd1,
        HOLD_FIRED    = 2'd2
    } hold_state_e;

    logic [3:0]         sync1_r;
    logic [3:0]         sync_q_r;
    logic [3:0][DW-1:0] db_cnt_r;
    logic [3:0][DW-1:0] db_cnt_nxt_s;
    logic [3:0]         held_r;
    logic [3:0]         held_nxt_s;
    logic [3:0]         press_s;
    hold_state_e        hold_state_r   [4];
    hold_state_e        hold_state_nxt_s [4];
    logic [3:0][LW-1:0] hold_cnt_r;
    logic [3:0][LW-1:0] hold_cnt_nxt_s;
    logic [3:0]         fire_s;
    logic [3:0]         led_state_r;
    logic [3:0]         led_state_nxt_s;
    logic [3:0]         press_pulse_r;
    logic               long_pulse_r;

    // Per-bit debounce: a mismatch must persist DEBOUNCE_CYCLES samples to be accepted
    always_comb begin
        held_nxt_s   = held_r;
        db_cnt_nxt_s = '0;
        for (int i = 0; i < 4; i++) begin
            if (sync_q_r[i] != held_r[i]) begin
                if (db_cnt_r[i] == DB_LAST) begin
                    held_nxt_s[i]   = sync_q_r[i];
                    db_cnt_nxt_s[i] = '0;
                end else begin
                    db_cnt_nxt_s[i] = db_cnt_r[i] + DW'(1);
                end
            end else begin
                db_cnt_nxt_s[i] = '0;
            end
        end
    end

    assign press_s = held_nxt_s & ~held_r;

    // Per-switch hold FSM; FIRED freezes the counter so a long hold fires once
    always_comb begin
        fire_s = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            hold_state_nxt_s[i] = hold_state_r[i];
            hold_cnt_nxt_s[i]   = hold_cnt_r[i];
            if (!held_nxt_s[i]) begin
                hold_state_nxt_s[i] = HOLD_IDLE;
                hold_cnt_nxt_s[i]   = '0;
            end else if (press_s[i]) begin
                hold_state_nxt_s[i] = HOLD_COUNTING;
                hold_cnt_nxt_s[i]   = '0;
            end else begin
                case (hold_state_r[i])
                    HOLD_IDLE: begin
                        hold_cnt_nxt_s[i] = '0;
                    end
                    HOLD_COUNTING: begin
                        if (hold_cnt_r[i] == LONG_LAST) begin
                            hold_state_nxt_s[i] = HOLD_FIRED;
                            fire_s[i]           = 1'b1;
                        end else begin
                            hold_cnt_nxt_s[i] = hold_cnt_r[i] + LW'(1);
                        end
                    end
                    HOLD_FIRED: begin
                        hold_cnt_nxt_s[i] = hold_cnt_r[i];
                    end
                    default: begin
                        hold_state_nxt_s[i] = HOLD_IDLE;
                        hold_cnt_nxt_s[i]   = '0;
                    end
                endcase
            end
        end
    end

    // LED latches: a long-press clear overrides any toggle in the same cycle
    always_comb begin
        if (|fire_s) begin
            led_state_nxt_s = 4'b0000;
        end else begin
            led_state_nxt_s = led_state_r ^ press_s;
        end
    end

    // State register for synchroniser, debounce, hold FSMs, latches and strobes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_r       <= 4'b0000;
            sync_q_r      <= 4'b0000;
            db_cnt_r      <= '0;
            held_r        <= 4'b0000;
            hold_cnt_r    <= '0;
            led_state_r   <= 4'b0000;
            press_pulse_r <= 4'b0000;
            long_pulse_r  <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                hold_state_r[i] <= HOLD_IDLE;
            end
        end else begin
            sync1_r       <= sw;
            sync_q_r      <= sync1_r;
            db_cnt_r      <= db_cnt_nxt_s;
            held_r        <= held_nxt_s;
            hold_cnt_r    <= hold_cnt_nxt_s;
            led_state_r   <= led_state_nxt_s;
            press_pulse_r <= press_s;
            long_pulse_r  <= |fire_s;
            for (int i = 0; i < 4; i++) begin
                hold_state_r[i] <= hold_state_nxt_s[i];
            end
        end
    end

    assign led_n       = ~led_state_r;
    assign press_pulse = press_pulse_r;
    assign long_pulse  = long_pulse_r;
    assign held        = held_r;

endmodule

// File: tb/tb_switch_led_ctrl.sv
// Directed bench for switch_led_ctrl (DEBOUNCE_CYCLES=4, LONG_CYCLES=16):
// expectations are queued when stimulus is applied and popped at each check.
module tb_switch_led_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] sw;
    logic [3:0] led_n;
    logic [3:0] press_pulse;
    logic       long_pulse;
    logic [3:0] held;

    int checks = 0;
    int passed = 0;

    typedef struct {
        string      tag;
        logic [3:0] led_n;
        logic [3:0] press;
        logic       lng;
        logic [3:0] held;
    } exp_t;

    exp_t sb[$];

    switch_led_ctrl #(
        .DEBOUNCE_CYCLES(4),
        .LONG_CYCLES    (16)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sw         (sw),
        .led_n      (led_n),
        .press_pulse(press_pulse),
        .long_pulse (long_pulse),
        .held       (held)
    );

    always #5 clk = ~clk;

    task automatic push(input string tag, input logic [3:0] l, input logic [3:0] p,
                        input logic lg, input logic [3:0] h);
        exp_t e;
        e.tag = tag; e.led_n = l; e.press = p; e.lng = lg; e.held = h;
        sb.push_back(e);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check();
        exp_t e;
        checks++;
        assert (sb.size() != 0) passed++;
        else $error("FAIL scoreboard: observed empty queue, expected an entry");
        if (sb.size() != 0) begin
            e = sb.pop_front();
            checks++;
            assert (led_n === e.led_n) passed++;
            else $error("FAIL %s led_n: observed %b expected %b", e.tag, led_n, e.led_n);
            checks++;
            assert (press_pulse === e.press) passed++;
            else $error("FAIL %s press_pulse: observed %b expected %b", e.tag, press_pulse, e.press);
            checks++;
            assert (long_pulse === e.lng) passed++;
            else $error("FAIL %s long_pulse: observed %b expected %b", e.tag, long_pulse, e.lng);
            checks++;
            assert (held === e.held) passed++;
            else $error("FAIL %s held: observed %b expected %b", e.tag, held, e.held);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        sw    = 4'b0000;
        #2;
        push("reset0", 4'b1111, 4'b0000, 1'b0, 4'b0000);
        check();
        @(posedge clk); #1; rst_n = 1'b1;
        step(2);

        // Clean press/release of sw[0]
        sw = 4'b0001;
        push("t2_pre",   4'b1111, 4'b0000, 1'b0, 4'b0000);
        push("t2_press", 4'b1110, 4'b0001, 1'b0, 4'b0001);
        push("t2_after", 4'b1110, 4'b0000, 1'b0, 4'b0001);
        step(5); check();
        step(1); check();
        step(1); check();
        step(3);
        sw = 4'b0000;
        push("t2_rel_pre", 4'b1110, 4'b0000, 1'b0, 4'b0001);
        push("t2_rel",     4'b1110, 4'b0000, 1'b0, 4'b0000);
        step(5); check();
        step(1); check();
        sw = 4'b0001;
        push("t2_press2", 4'b1111, 4'b0001, 1'b0, 4'b0001);
        step(6); check();
        sw = 4'b0000;
        push("t2_rel2", 4'b1111, 4'b0000, 1'b0, 4'b0000);
        step(6); check();
        step(2);

        // Bounce on sw[2]: no acceptance until it stays high
        for (int b = 0; b < 4; b++) begin
            sw = (b % 2 == 0) ? 4'b0100 : 4'b0000;
            for (int c = 0; c < 2; c++) begin
                push("t3_bounce", 4'b1111, 4'b0000, 1'b0, 4'b0000);
                step(1); check();
            end
        end
        sw = 4'b0100;
        push("t3_pre",   4'b1111, 4'b0000, 1'b0, 4'b0000);
        push("t3_press", 4'b1011, 4'b0100, 1'b0, 4'b0100);
        step(5); check();
        step(1); check();

        // Asynchronous reset mid-press with an LED lit, switch kept held
        step(1);
        #2;
        rst_n = 1'b0;
        #1;
        push("t1_reset", 4'b1111, 4'b0000, 1'b0, 4'b0000);
        check();
        @(posedge clk); #1; rst_n = 1'b1;
        push("t1_pre",     4'b1111, 4'b0000, 1'b0, 4'b0000);
        push("t1_repress", 4'b1011, 4'b0100, 1'b0, 4'b0100);
        step(5); check();
        step(1); check();
        sw = 4'b0000;
        push("t1_rel", 4'b1011, 4'b0000, 1'b0, 4'b0000);
        step(6); check();
        rst_n = 1'b0;
        #1;
        push("t1_reset2", 4'b1111, 4'b0000, 1'b0, 4'b0000);
        check();
        @(posedge clk); #1; rst_n = 1'b1;
        step(2);

        // Simultaneous presses of sw[1] and sw[3]
        sw = 4'b1010;
        push("t4_pre",   4'b1111, 4'b0000, 1'b0, 4'b0000);
        push("t4_press", 4'b0101, 4'b1010, 1'b0, 4'b1010);
        step(5); check();
        step(1); check();
        sw = 4'b0000;
        push("t4_rel", 4'b0101, 4'b0000, 1'b0, 4'b0000);
        step(6); check();
        step(2);

        // Long press of sw[0]: toggle first, clear after 16 cycles, fire once
        sw = 4'b0001;
        push("t5_press", 4'b0100, 4'b0001, 1'b0, 4'b0001);
        step(6); check();
        push("t5_prefire", 4'b0100, 4'b0000, 1'b0, 4'b0001);
        step(15); check();
        push("t5_fire", 4'b1111, 4'b0000, 1'b1, 4'b0001);
        step(1); check();
        for (int k = 0; k < 40; k++) begin
            push("t5_nofire", 4'b1111, 4'b0000, 1'b0, 4'b0001);
            step(1); check();
        end
        sw = 4'b0000;
        push("t5_rel", 4'b1111, 4'b0000, 1'b0, 4'b0000);
        step(6); check();
        step(2);

        // sw[1] press edge coincides with sw[3] reaching FIRED: clear wins
        sw = 4'b1000;
        push("t6_press3", 4'b0111, 4'b1000, 1'b0, 4'b1000);
        step(6); check();
        step(10);
        sw = 4'b1010;
        push("t6_pre",   4'b0111, 4'b0000, 1'b0, 4'b1000);
        push("t6_clear", 4'b1111, 4'b0010, 1'b1, 4'b1010);
        push("t6_after", 4'b1111, 4'b0000, 1'b0, 4'b1010);
        step(5); check();
        step(1); check();
        step(1); check();
        sw = 4'b0000;
        step(8);

        checks++;
        assert (sb.size() == 0) passed++;
        else $error("FAIL scoreboard_drain: observed %0d leftover entries, expected 0", sb.size());

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
